// File: rtl/vdp_super_rgb_mixer_if.sv
// Pixel-path bundle between the video timing/source stages and the super RGB mixer.
// master drives pixels and timing and reads the mixed RGB; slave is the mixer.
interface vdp_super_rgb_mixer_if;
    logic        vdp_super;
    logic [7:0]  super_red;
    logic [7:0]  super_green;
    logic [7:0]  super_blue;
    logic [5:0]  vdp_red;
    logic [5:0]  vdp_green;
    logic [5:0]  vdp_blue;
    logic        blank;
    logic [10:0] cx;
    logic [9:0]  cy;
    logic [7:0]  out_red;
    logic [7:0]  out_green;
    logic [7:0]  out_blue;
    logic        out_src_super;
    logic [1:0]  mix_state;

    modport master (
        output vdp_super, super_red, super_green, super_blue,
        output vdp_red, vdp_green, vdp_blue, blank, cx, cy,
        input  out_red, out_green, out_blue, out_src_super, mix_state
    );

    modport slave (
        input  vdp_super, super_red, super_green, super_blue,
        input  vdp_red, vdp_green, vdp_blue, blank, cx, cy,
        output out_red, out_green, out_blue, out_src_super, mix_state
    );
endinterface

// File: rtl/vdp_super_rgb_mixer.sv
// Final RGB stage: delay-aligns super-res RGB to the legacy path and switches source at frame start.
// Define SUPER_RGB_MIXER_FADE_EN for a per-frame fade out/in; otherwise the switch is a hard cut.
module vdp_super_rgb_mixer #(
    parameter int unsigned PIPE_DELAY = 3,
    parameter int unsigned FADE_STEPS = 4
) (
    input logic                  clk,
    input logic                  reset,
    vdp_super_rgb_mixer_if.slave bus
);
    typedef enum logic [1:0] {
        StLegacy   = 2'd0,
        StFadeDown = 2'd1,
        StFadeUp   = 2'd2,
        StSuper    = 2'd3
    } mix_state_e;

    localparam logic [3:0] MaxLevel = 4'(FADE_STEPS);

    logic [PIPE_DELAY-1:0][23:0] dl_q, dl_d;
    mix_state_e                  state_q, state_d;
    logic [3:0]                  level_q, level_d;
    logic                        cur_src_q, cur_src_d;
    logic [23:0]                 rgb_q, rgb_d;

    logic        frame_tick;
    logic        want;
    logic [23:0] legacy_rgb;
    logic [23:0] src_rgb;
    logic [3:0]  shift;

    assign frame_tick = (bus.cx == '0) && (bus.cy == '0);
    assign want       = bus.vdp_super;
    assign legacy_rgb = {bus.vdp_red, bus.vdp_red[5:4], bus.vdp_green, bus.vdp_green[5:4],
                         bus.vdp_blue, bus.vdp_blue[5:4]};
    assign src_rgb    = cur_src_q ? dl_q[PIPE_DELAY-1] : legacy_rgb;
    // Clamp keeps the attenuation bounded even if level ever exceeds the fade depth.
    assign shift      = (level_q > MaxLevel) ? MaxLevel : level_q;

    always_comb begin
        dl_d    = dl_q;
        dl_d[0] = {bus.super_red, bus.super_green, bus.super_blue};
        for (int i = 1; i < int'(PIPE_DELAY); i++) begin
            dl_d[i] = dl_q[i-1];
        end
    end

    always_comb begin
        rgb_d = '0;
        if (!bus.blank) begin
            rgb_d[23:16] = src_rgb[23:16] >> shift;
            rgb_d[15:8]  = src_rgb[15:8] >> shift;
            rgb_d[7:0]   = src_rgb[7:0] >> shift;
        end
    end

    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        cur_src_d = cur_src_q;
        if (frame_tick) begin
`ifdef SUPER_RGB_MIXER_FADE_EN
            case (state_q)
                StLegacy, StSuper: begin
                    if (want != cur_src_q) begin
                        state_d = StFadeDown;
                        level_d = 4'd1;
                    end
                end
                StFadeDown: begin
                    // A withdrawn request turns the fade around without swapping source.
                    if (want == cur_src_q) begin
                        state_d = StFadeUp;
                    end else if (level_q < MaxLevel) begin
                        level_d = level_q + 4'd1;
                    end else begin
                        cur_src_d = ~cur_src_q;
                        state_d   = StFadeUp;
                    end
                end
                StFadeUp: begin
                    if (want != cur_src_q) begin
                        state_d = StFadeDown;
                    end else if (level_q > 4'd1) begin
                        level_d = level_q - 4'd1;
                    end else begin
                        level_d = '0;
                        state_d = cur_src_q ? StSuper : StLegacy;
                    end
                end
                default: state_d = StLegacy;
            endcase
`else
            level_d = '0;
            if (want != cur_src_q) begin
                cur_src_d = want;
                state_d   = want ? StSuper : StLegacy;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dl_q      <= '0;
            state_q   <= StLegacy;
            level_q   <= '0;
            cur_src_q <= 1'b0;
            rgb_q     <= '0;
        end else begin
            dl_q      <= dl_d;
            state_q   <= state_d;
            level_q   <= level_d;
            cur_src_q <= cur_src_d;
            rgb_q     <= rgb_d;
        end
    end

    assign bus.out_red       = rgb_q[23:16];
    assign bus.out_green     = rgb_q[15:8];
    assign bus.out_blue      = rgb_q[7:0];
    assign bus.out_src_super = cur_src_q;
    assign bus.mix_state     = state_q;
endmodule

// File: tb/tb_vdp_super_rgb_mixer.sv
// Self-checking bench for vdp_super_rgb_mixer (PIPE_DELAY=3, FADE_STEPS=2).
// Expectations follow SUPER_RGB_MIXER_FADE_EN the same way the design does.
module tb_vdp_super_rgb_mixer;
    localparam int unsigned PD = 3;
    localparam int unsigned FS = 2;

    typedef struct {
        bit         vs;
        logic [7:0] exp_chan;
        logic [1:0] exp_state;
        bit         exp_src;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    vdp_super_rgb_mixer_if bus ();

    vdp_super_rgb_mixer #(
        .PIPE_DELAY(PD),
        .FADE_STEPS(FS)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Reference model: history of super pixels, current source, fade depth and fade phase.
    logic [23:0] m_sq[$];
    bit          m_cur;
    int          m_lvl;
    int          m_phase;  // 0 steady, 1 fading out, 2 fading in
    logic [23:0] exp_rgb;
    logic [1:0]  exp_state;
    bit          exp_src;
    vec_t        tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, want %0h at %0t", name, act, req, $time);
    endtask

    function automatic logic [7:0] expand(input logic [5:0] v);
        int x;
        x = int'(v);
        return 8'(x * 4 + x / 16);
    endfunction

    function automatic logic [7:0] dim(input logic [7:0] c, input int l);
        if (l >= 8) return 8'h00;
        return 8'(int'(c) / (2 ** l));
    endfunction

    task automatic model_reset();
        m_sq.delete();
        for (int i = 0; i < int'(PD); i++) m_sq.push_back(24'h0);
        m_cur   = 1'b0;
        m_lvl   = 0;
        m_phase = 0;
    endtask

    task automatic model_frame(input bit want);
`ifdef SUPER_RGB_MIXER_FADE_EN
        if (m_phase == 0) begin
            if (want != m_cur) begin
                m_phase = 1;
                m_lvl   = 1;
            end
        end else if (m_phase == 1) begin
            if (want == m_cur) m_phase = 2;
            else if (m_lvl < int'(FS)) m_lvl = m_lvl + 1;
            else begin
                m_cur   = !m_cur;
                m_phase = 2;
            end
        end else begin
            if (want != m_cur) m_phase = 1;
            else if (m_lvl > 1) m_lvl = m_lvl - 1;
            else begin
                m_lvl   = 0;
                m_phase = 0;
            end
        end
`else
        if (want != m_cur) m_cur = want;
`endif
    endtask

    function automatic logic [23:0] out_rgb();
        return {bus.out_red, bus.out_green, bus.out_blue};
    endfunction

    task automatic step(input bit vs, input logic [23:0] sup, input logic [17:0] leg,
                        input bit blk, input bit tick);
        logic [23:0] tap;
        logic [23:0] src;
        int          cx_v;
        int          cy_v;
        bus.vdp_super   = vs;
        bus.super_red   = sup[23:16];
        bus.super_green = sup[15:8];
        bus.super_blue  = sup[7:0];
        bus.vdp_red     = leg[17:12];
        bus.vdp_green   = leg[11:6];
        bus.vdp_blue    = leg[5:0];
        bus.blank       = blk;
        if (tick) begin
            cx_v = 0;
            cy_v = 0;
        end else begin
            cy_v = int'($urandom_range(0, 1023));
            cx_v = (cy_v == 0) ? int'($urandom_range(1, 2047)) : int'($urandom_range(0, 2047));
        end
        bus.cx = 11'(cx_v);
        bus.cy = 10'(cy_v);
        tap = m_sq.pop_front();
        m_sq.push_back(sup);
        src = m_cur ? tap : {expand(leg[17:12]), expand(leg[11:6]), expand(leg[5:0])};
        exp_rgb = blk ? 24'h0 : {dim(src[23:16], m_lvl), dim(src[15:8], m_lvl),
                                 dim(src[7:0], m_lvl)};
        if (tick) model_frame(vs);
        exp_src   = m_cur;
        exp_state = (m_phase == 0) ? (m_cur ? 2'd3 : 2'd0) : 2'(m_phase);
        @(posedge clk);
        #1;
        chk("model_rgb", {8'h0, out_rgb()}, {8'h0, exp_rgb});
        chk("model_src", {31'h0, bus.out_src_super}, {31'h0, exp_src});
        chk("model_state", {30'h0, bus.mix_state}, {30'h0, exp_state});
    endtask

    // Reset asserted between clock edges must clear the outputs before the next edge.
    task automatic async_reset(input string name);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk({name, "_rgb"}, {8'h0, out_rgb()}, 32'h0);
        chk({name, "_state"}, {30'h0, bus.mix_state}, 32'h0);
        chk({name, "_src"}, {31'h0, bus.out_src_super}, 32'h0);
        @(posedge clk);
        #3;
        reset = 1'b0;
    endtask

    initial begin
        bit vs;
`ifdef SUPER_RGB_MIXER_FADE_EN
        tbl[0] = '{1'b1, 8'h7F, 2'd1, 1'b0};
        tbl[1] = '{1'b1, 8'h3F, 2'd1, 1'b0};
        tbl[2] = '{1'b1, 8'h20, 2'd2, 1'b1};
        tbl[3] = '{1'b1, 8'h40, 2'd2, 1'b1};
        tbl[4] = '{1'b1, 8'h80, 2'd3, 1'b1};
        tbl[5] = '{1'b1, 8'h80, 2'd3, 1'b1};
`else
        tbl[0] = '{1'b1, 8'h80, 2'd3, 1'b1};
        tbl[1] = '{1'b1, 8'h80, 2'd3, 1'b1};
        tbl[2] = '{1'b0, 8'hFF, 2'd0, 1'b0};
        tbl[3] = '{1'b1, 8'h80, 2'd3, 1'b1};
        tbl[4] = '{1'b1, 8'h80, 2'd3, 1'b1};
        tbl[5] = '{1'b1, 8'h80, 2'd3, 1'b1};
`endif
        bus.vdp_super   = 1'b0;
        bus.super_red   = '0;
        bus.super_green = '0;
        bus.super_blue  = '0;
        bus.vdp_red     = '0;
        bus.vdp_green   = '0;
        bus.vdp_blue    = '0;
        bus.blank       = 1'b0;
        bus.cx          = 11'd1;
        bus.cy          = 10'd1;
        model_reset();
        #12;
        chk("reset_rgb", {8'h0, out_rgb()}, 32'h0);
        chk("reset_state", {30'h0, bus.mix_state}, 32'h0);
        chk("reset_src", {31'h0, bus.out_src_super}, 32'h0);
        reset = 1'b0;

        // Request raised mid-frame: nothing may change until the frame boundary.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 24'h808080, 18'h3FFFF, 1'b0, 1'b0);
            chk("legacy_ff", {8'h0, out_rgb()}, 32'hFFFFFF);
            chk("legacy_state", {30'h0, bus.mix_state}, 32'h0);
        end

        for (int i = 0; i < 6; i++) begin
            step(tbl[i].vs, 24'h808080, 18'h3FFFF, 1'b0, 1'b1);
            step(tbl[i].vs, 24'h808080, 18'h3FFFF, 1'b0, 1'b0);
            chk("frame_rgb", {8'h0, out_rgb()}, {8'h0, {3{tbl[i].exp_chan}}});
            chk("frame_state", {30'h0, bus.mix_state}, {30'h0, tbl[i].exp_state});
            chk("frame_src", {31'h0, bus.out_src_super}, {31'h0, tbl[i].exp_src});
        end

        // One-clock red pulse on the super path emerges PIPE_DELAY+1 clocks later.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, (i == 0) ? 24'hAA8080 : 24'h808080, 18'h3FFFF, 1'b0, 1'b0);
            chk("pulse_red", {24'h0, bus.out_red}, (i == 3) ? 32'hAA : 32'h80);
        end

        async_reset("rst_clean");
        step(1'b1, 24'h808080, 18'h3FFFF, 1'b0, 1'b1);
        step(1'b1, 24'h808080, 18'h3FFFF, 1'b0, 1'b0);
        step(1'b1, 24'h808080, 18'h3FFFF, 1'b0, 1'b1);
        step(1'b1, 24'h808080, 18'h3FFFF, 1'b0, 1'b0);
`ifdef SUPER_RGB_MIXER_FADE_EN
        chk("midfade_rgb", {8'h0, out_rgb()}, 32'h3F3F3F);
        chk("midfade_state", {30'h0, bus.mix_state}, 32'h1);
`else
        chk("midfade_rgb", {8'h0, out_rgb()}, 32'h808080);
        chk("midfade_state", {30'h0, bus.mix_state}, 32'h3);
`endif
        async_reset("rst_midfade");
        step(1'b0, 24'h808080, 18'h3FFFF, 1'b0, 1'b0);
        chk("post_reset_rgb", {8'h0, out_rgb()}, 32'hFFFFFF);
        chk("post_reset_state", {30'h0, bus.mix_state}, 32'h0);

`ifdef SUPER_RGB_MIXER_FADE_EN
        // Request withdrawn during fade-out: fade back in on legacy, never swapping source.
        step(1'b1, 24'h808080, 18'h3FFFF, 1'b0, 1'b1);
        step(1'b1, 24'h808080, 18'h3FFFF, 1'b0, 1'b0);
        chk("wd_down_rgb", {8'h0, out_rgb()}, 32'h7F7F7F);
        chk("wd_down_state", {30'h0, bus.mix_state}, 32'h1);
        step(1'b0, 24'h808080, 18'h3FFFF, 1'b0, 1'b0);
        step(1'b0, 24'h808080, 18'h3FFFF, 1'b0, 1'b1);
        step(1'b0, 24'h808080, 18'h3FFFF, 1'b0, 1'b0);
        chk("wd_up_rgb", {8'h0, out_rgb()}, 32'h7F7F7F);
        chk("wd_up_state", {30'h0, bus.mix_state}, 32'h2);
        chk("wd_up_src", {31'h0, bus.out_src_super}, 32'h0);
        step(1'b0, 24'h808080, 18'h3FFFF, 1'b0, 1'b1);
        step(1'b0, 24'h808080, 18'h3FFFF, 1'b0, 1'b0);
        chk("wd_end_rgb", {8'h0, out_rgb()}, 32'hFFFFFF);
        chk("wd_end_state", {30'h0, bus.mix_state}, 32'h0);
        chk("wd_end_src", {31'h0, bus.out_src_super}, 32'h0);
`endif

        vs = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 11) == 0) vs = !vs;
            step(vs, 24'($urandom), 18'($urandom), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 5) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
